dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester (core / loader) arbiter in front of a single-port synchronous data memory.
// Define DMEM_ARBITER_LOCK_EN to add the l_lock input and the LOCKED ownership state.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [7:0]  c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [7:0]  l_addr,
  input  logic [31:0] l_wdata,
  output logic        l_gnt,
  output logic        l_rvalid,
`ifdef DMEM_ARBITER_LOCK_EN
  input  logic        l_lock,
`endif
  output logic [31:0] rdata,
  output logic [7:0]  mem_address,
  output logic [31:0] mem_data,
  output logic        mem_wren,
  input  logic [31:0] mem_q
);

  typedef enum logic [1:0] {CORE_PRI, LOADER_PRI, LOCKED} state_t;

  localparam logic [3:0] LAST_CORE = 4'(STARVE_LIMIT - 1);

  state_t      state;
  logic [3:0]  starve_cnt;
  logic        rd_pending;
  logic        rd_owner;
  logic [7:0]  addr_q;
  logic [31:0] data_q;
  logic        lock_req;

`ifdef DMEM_ARBITER_LOCK_EN
  assign lock_req = l_lock;
`else
  assign lock_req = 1'b0;
`endif

  // Grants are gated by rst_n so nothing is granted while reset is held.
  always_comb begin
    c_gnt = 1'b0;
    l_gnt = 1'b0;
    if (rst_n) begin
      case (state)
        CORE_PRI: begin
          c_gnt = c_req;
          l_gnt = l_req & ~c_req;
        end
        LOADER_PRI: begin
          l_gnt = l_req;
          c_gnt = c_req & ~l_req;
        end
        LOCKED: begin
          l_gnt = l_req;
        end
        default: begin
          c_gnt = 1'b0;
          l_gnt = 1'b0;
        end
      endcase
    end
  end

  assign mem_address = c_gnt ? c_addr  : (l_gnt ? l_addr  : addr_q);
  assign mem_data    = c_gnt ? c_wdata : (l_gnt ? l_wdata : data_q);
  assign mem_wren    = (c_gnt & c_we) | (l_gnt & l_we);

  assign c_rvalid = rd_pending & ~rd_owner;
  assign l_rvalid = rd_pending & rd_owner;
  assign rdata    = rd_pending ? mem_q : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CORE_PRI;
      starve_cnt <= 4'd0;
    end else begin
      case (state)
        CORE_PRI, LOADER_PRI: begin
          if (l_gnt && lock_req) begin
            state      <= LOCKED;
            starve_cnt <= 4'd0;
          end else begin
            if (l_gnt || !l_req)
              starve_cnt <= 4'd0;
            else if (c_gnt)
              starve_cnt <= starve_cnt + 4'd1;
            // Hand priority to the loader on the edge accepting the last allowed core transfer.
            if (state == LOADER_PRI) begin
              if (l_gnt || !l_req)
                state <= CORE_PRI;
            end else if (c_gnt && l_req && starve_cnt == LAST_CORE) begin
              state <= LOADER_PRI;
            end
          end
        end
        LOCKED: begin
          if ((l_gnt && !lock_req) || !l_req)
            state <= CORE_PRI;
        end
        default: begin
          state      <= CORE_PRI;
          starve_cnt <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
      addr_q     <= 8'd0;
      data_q     <= 32'd0;
    end else begin
      rd_pending <= (c_gnt & ~c_we) | (l_gnt & ~l_we);
      rd_owner   <= l_gnt;
      if (c_gnt || l_gnt) begin
        addr_q <= mem_address;
        data_q <= mem_data;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic against a behavioural model.
// Lock scenarios run only when DMEM_ARBITER_LOCK_EN is defined.
module tb_dmem_arbiter;

  localparam int LIMIT = 4;
`ifdef DMEM_ARBITER_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_we, l_req, l_we;
  logic [7:0]  c_addr, l_addr;
  logic [31:0] c_wdata, l_wdata;
  logic        c_gnt, c_rvalid, l_gnt, l_rvalid;
  logic [31:0] rdata, mem_data, mem_q;
  logic [7:0]  mem_address;
  logic        mem_wren;
`ifdef DMEM_ARBITER_LOCK_EN
  logic        l_lock;
`endif

  dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid),
`ifdef DMEM_ARBITER_LOCK_EN
    .l_lock(l_lock),
`endif
    .rdata(rdata), .mem_address(mem_address), .mem_data(mem_data),
    .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  bit [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_wren) mem[mem_address] <= mem_data;
    mem_q <= mem[mem_address];
  end

  // Reference model: who has priority, how long the loader has waited, and the pending read.
  bit        loader_turn, locked;
  int        core_streak;
  bit        pend_valid, pend_is_loader;
  bit [31:0] pend_data;
  bit [7:0]  last_addr;
  bit [31:0] last_data;
  bit [31:0] shadow [256];
  bit        seen_c_gnt;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit rn,
                               input bit cr, input bit cw, input bit [7:0] ca, input bit [31:0] cd,
                               input bit lr, input bit lw, input bit [7:0] la, input bit [31:0] ld,
                               input bit lk);
    bit        eg_c, eg_l, ewr, lk_eff;
    bit [7:0]  ea;
    bit [31:0] ed;
    @(negedge clk);
    rst_n = rn; c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    l_req = lr; l_we = lw; l_addr = la; l_wdata = ld;
`ifdef DMEM_ARBITER_LOCK_EN
    l_lock = lk;
`endif
    lk_eff = LOCK_EN && lk;
    #1;
    eg_c = 1'b0;
    eg_l = 1'b0;
    if (!rn) begin
      loader_turn = 1'b0; locked = 1'b0; core_streak = 0;
      pend_valid = 1'b0; last_addr = 8'd0; last_data = 32'd0;
    end else if (locked) begin
      eg_l = lr;
    end else if (loader_turn) begin
      eg_l = lr;
      eg_c = cr && !lr;
    end else begin
      eg_c = cr;
      eg_l = lr && !cr;
    end
    ea  = eg_c ? ca : (eg_l ? la : last_addr);
    ed  = eg_c ? cd : (eg_l ? ld : last_data);
    ewr = (eg_c && cw) || (eg_l && lw);
    seen_c_gnt = c_gnt;
    checkOutput("c_gnt", c_gnt, eg_c);
    checkOutput("l_gnt", l_gnt, eg_l);
    checkOutput("mem_wren", mem_wren, ewr);
    checkOutput("mem_address", mem_address, ea);
    checkOutput("mem_data", mem_data, ed);
    checkOutput("c_rvalid", c_rvalid, pend_valid && !pend_is_loader);
    checkOutput("l_rvalid", l_rvalid, pend_valid && pend_is_loader);
    checkOutput("rdata", rdata, pend_valid ? pend_data : 32'd0);
    @(posedge clk);
    if (rn) begin
      pend_valid     = (eg_c && !cw) || (eg_l && !lw);
      pend_is_loader = eg_l;
      pend_data      = shadow[ea];
      if (ewr) shadow[ea] = ed;
      if (eg_c || eg_l) begin
        last_addr = ea;
        last_data = ed;
      end
      if (locked) begin
        if ((eg_l && !lk_eff) || !lr) locked = 1'b0;
      end else if (eg_l && lk_eff) begin
        locked = 1'b1; loader_turn = 1'b0; core_streak = 0;
      end else begin
        if (eg_l || !lr) core_streak = 0;
        else if (eg_c) core_streak++;
        if (loader_turn) begin
          if (eg_l || !lr) loader_turn = 1'b0;
        end else if (core_streak == LIMIT) begin
          loader_turn = 1'b1;
        end
      end
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0, 0);
  endtask

  initial begin
    rst_n = 1'b0; c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
`ifdef DMEM_ARBITER_LOCK_EN
    l_lock = 0;
`endif
    $display("[TB] start, LOCK_EN=%0d", LOCK_EN);

    // Requests held high during reset must not be granted.
    repeat (3) applyStimulus(0, 1, 0, 8'h10, 32'h1, 1, 1, 8'h20, 32'h2, 0);
    idleCycle();

    // Core read of a preloaded word.
    applyStimulus(1, 0, 0, 8'h00, 32'h0, 1, 1, 8'h10, 32'hDEADBEEF, 0);
    applyStimulus(1, 1, 0, 8'h10, 32'h0, 0, 0, 8'h00, 32'h0, 0);
    idleCycle();

    // Alternating back-to-back reads.
    applyStimulus(1, 0, 0, 8'h00, 32'h0, 1, 1, 8'h01, 32'h11111111, 0);
    applyStimulus(1, 0, 0, 8'h00, 32'h0, 1, 1, 8'h02, 32'h22222222, 0);
    applyStimulus(1, 1, 0, 8'h01, 32'h0, 0, 0, 8'h00, 32'h0, 0);
    applyStimulus(1, 0, 0, 8'h00, 32'h0, 1, 0, 8'h02, 32'h0, 0);
    idleCycle();

    // Loader write followed by core read of the same address.
    applyStimulus(1, 0, 0, 8'h00, 32'h0, 1, 1, 8'hFF, 32'h0000CAFE, 0);
    applyStimulus(1, 1, 0, 8'hFF, 32'h0, 0, 0, 8'h00, 32'h0, 0);
    idleCycle();

    // Reset dropped while a core read response is outstanding.
    applyStimulus(1, 1, 0, 8'h10, 32'h0, 0, 0, 8'h00, 32'h0, 0);
    applyStimulus(0, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0, 0);
    idleCycle();
    idleCycle();

    // Both requesters saturated: core gets LIMIT grants, then one loader grant.
    for (int i = 0; i < 2 * (LIMIT + 1); i++) begin
      applyStimulus(1, 1, 0, 8'(i), 32'h0, 1, 0, 8'(i + 8'h40), 32'h0, 0);
      checkOutput("starve_pattern", seen_c_gnt, (i % (LIMIT + 1)) != LIMIT);
    end
    idleCycle();

`ifdef DMEM_ARBITER_LOCK_EN
    // Loader holds ownership across three locked writes while the core waits.
    applyStimulus(1, 0, 0, 8'h00, 32'h0, 1, 1, 8'h80, 32'hA0, 1);
    applyStimulus(1, 1, 0, 8'h81, 32'h0, 1, 1, 8'h81, 32'hA1, 1);
    applyStimulus(1, 1, 0, 8'h81, 32'h0, 1, 1, 8'h82, 32'hA2, 1);
    applyStimulus(1, 1, 0, 8'h81, 32'h0, 1, 1, 8'h83, 32'hA3, 0);
    applyStimulus(1, 1, 0, 8'h81, 32'h0, 0, 0, 8'h00, 32'h0, 0);
    checkOutput("lock_release_core", seen_c_gnt, 1'b1);
    idleCycle();
`endif

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 49) != 0,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                    8'($urandom_range(0, 15)), $urandom,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                    8'($urandom_range(0, 15)), $urandom,
                    $urandom_range(0, 2) == 0);
    end
    idleCycle();
    idleCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
